// File: rtl/axis_bram_slave_cfg_pkg.sv
// Shared FFT loader definitions: size limits, default widths and loader state encoding.
package axis_bram_slave_cfg_pkg;

    localparam int FFT_LOG2_N_MIN    = 3;
    localparam int FFT_LOG2_N_MAX    = 12;
    localparam int FFT_ADDR_WIDTH    = FFT_LOG2_N_MAX;
    localparam int FFT_SAMPLE_WIDTH  = 16;
    localparam int FFT_DATA_WIDTH    = 2 * FFT_SAMPLE_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fft_addr_bitrev.sv
// Runtime-length bit reverser: reverses the low log2_n bits of addr, upper bits stay 0.
module fft_addr_bitrev
    import axis_bram_slave_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = FFT_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [3:0]            log2_n,
    output logic [ADDR_WIDTH-1:0] rev
);

    logic [ADDR_WIDTH-1:0] full_rev;

    for (genvar i = 0; i < ADDR_WIDTH; i++) begin : g_rev
        assign full_rev[i] = addr[ADDR_WIDTH-1-i];
    end

    // addr is already masked to log2_n bits, so the low bits of full_rev are 0
    // and a right shift lines the reversed field up at bit 0.
    assign rev = full_rev >> (ADDR_WIDTH - int'(log2_n));

endmodule

// File: rtl/axis_bram_slave_cfg.sv
// AXI-Stream to FFT BRAM loader, direct or Hermitian-expanded, with tlast framing checks.
// Define AXIS_BRAM_BITREV_EN for bit-reversed write addresses (in-place DIT FFT).
module axis_bram_slave_cfg
    import axis_bram_slave_cfg_pkg::*;
#(
    parameter int LOG2_N_MAX   = FFT_LOG2_N_MAX,
    parameter int LOG2_N_MIN   = FFT_LOG2_N_MIN,
    parameter int SAMPLE_WIDTH = FFT_SAMPLE_WIDTH,
    parameter int ADDR_WIDTH   = LOG2_N_MAX,
    parameter int DATA_WIDTH   = 2 * SAMPLE_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [3:0]            cfg_log2_n,
    input  logic                  cfg_hermitian,
    output logic                  busy,
    output logic                  done,
    output logic                  err_cfg,
    output logic                  err_tlast_early,
    output logic                  err_tlast_missing,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [63:0]           s_axis_tdata,
    input  logic [7:0]            s_axis_tkeep,
    output logic [ADDR_WIDTH-1:0] waddra,
    output logic [DATA_WIDTH-1:0] wdataa,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] waddrb,
    output logic [DATA_WIDTH-1:0] wdatab,
    output logic                  web
);

    localparam int SW = SAMPLE_WIDTH;
    localparam int AW = ADDR_WIDTH;

    function automatic logic [SW-1:0] sat_neg(input logic [SW-1:0] x);
        if (x == {1'b1, {(SW-1){1'b0}}})
            return {1'b0, {(SW-1){1'b1}}};
        return (~x) + 1'b1;
    endfunction

    state_t          state, state_nxt;
    logic [3:0]      log2_n_q;
    logic            herm_q;
    logic [AW-1:0]   k;
    logic            err_cfg_q, err_early_q, err_missing_q;

    logic            cfg_ok, start, accept, at_last, tlast_early, mirror_en;
    logic [AW:0]     n_val, last_idx, k_ext, mirror;
    logic [AW-1:0]   mask, addr_a_nat, addr_b_nat, addr_a, addr_b;
    logic [SW-1:0]   re, im;
    logic            unused_ok;

    assign cfg_ok = ({1'b0, cfg_log2_n} >= 5'(LOG2_N_MIN)) &&
                    ({1'b0, cfg_log2_n} <= 5'(LOG2_N_MAX));
    assign start  = (state == IDLE) && go && cfg_ok;
    assign accept = (state == WRITE) && s_axis_tvalid;

    assign n_val       = (AW+1)'(1) << log2_n_q;
    assign mask        = AW'(n_val - 1'b1);
    assign last_idx    = herm_q ? (n_val >> 1) : (n_val - 1'b1);
    assign k_ext       = {1'b0, k};
    assign at_last     = (k_ext == last_idx);
    assign tlast_early = s_axis_tlast && (k_ext < last_idx);
    // DC (k=0) and Nyquist (k=N/2) are their own mirrors, so only 0<k<N/2 gets a port-B copy.
    assign mirror_en   = herm_q && (k != '0) && (k_ext < (n_val >> 1));
    assign mirror      = n_val - k_ext;
    assign addr_a_nat  = k & mask;
    assign addr_b_nat  = mirror[AW-1:0] & mask;

    assign re = s_axis_tdata[SW-1:0];
    assign im = s_axis_tdata[32+SW-1:32];
    assign unused_ok = ^{s_axis_tkeep, s_axis_tdata};

`ifdef AXIS_BRAM_BITREV_EN
    fft_addr_bitrev #(.ADDR_WIDTH(AW)) u_rev_a (
        .addr   (addr_a_nat),
        .log2_n (log2_n_q),
        .rev    (addr_a)
    );
    fft_addr_bitrev #(.ADDR_WIDTH(AW)) u_rev_b (
        .addr   (addr_b_nat),
        .log2_n (log2_n_q),
        .rev    (addr_b)
    );
`else
    assign addr_a = addr_a_nat;
    assign addr_b = addr_b_nat;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WRITE;
            WRITE:   if (accept && (s_axis_tlast || at_last)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        s_axis_tready = (state == WRITE);
        done          = (state == DONE);
        wea           = accept;
        waddra        = accept ? addr_a : '0;
        wdataa        = accept ? DATA_WIDTH'({re, im}) : '0;
        web           = accept && mirror_en;
        waddrb        = web ? addr_b : '0;
        wdatab        = web ? DATA_WIDTH'({re, sat_neg(im)}) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            log2_n_q      <= '0;
            herm_q        <= 1'b0;
            k             <= '0;
            err_cfg_q     <= 1'b0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
        end else begin
            err_cfg_q <= (state == IDLE) && go && !cfg_ok;
            if (start) begin
                log2_n_q      <= cfg_log2_n;
                herm_q        <= cfg_hermitian;
                k             <= '0;
                err_early_q   <= 1'b0;
                err_missing_q <= 1'b0;
            end else if (accept) begin
                k <= k + 1'b1;
                if (tlast_early)
                    err_early_q <= 1'b1;
                if (at_last && !s_axis_tlast)
                    err_missing_q <= 1'b1;
            end
        end
    end

    assign err_cfg           = err_cfg_q;
    assign err_tlast_early   = err_early_q;
    assign err_tlast_missing = err_missing_q;

endmodule

// File: tb/tb_axis_bram_slave_cfg.sv
// Bench for axis_bram_slave_cfg: frame table plus hand sequences, BRAM writes checked via scoreboard.
module tb_axis_bram_slave_cfg;

    localparam int SW = 16;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic [3:0]    cfg_log2_n = '0;
    logic          cfg_hermitian = 1'b0;
    logic          busy, done, err_cfg, err_tlast_early, err_tlast_missing;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [63:0]   s_axis_tdata = '0;
    logic [7:0]    s_axis_tkeep = '0;
    logic [AW-1:0] waddra, waddrb;
    logic [DW-1:0] wdataa, wdatab;
    logic          wea, web;

    axis_bram_slave_cfg dut (
        .clk               (clk),
        .reset             (reset),
        .go                (go),
        .cfg_log2_n        (cfg_log2_n),
        .cfg_hermitian     (cfg_hermitian),
        .busy              (busy),
        .done              (done),
        .err_cfg           (err_cfg),
        .err_tlast_early   (err_tlast_early),
        .err_tlast_missing (err_tlast_missing),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tlast      (s_axis_tlast),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tkeep      (s_axis_tkeep),
        .waddra            (waddra),
        .wdataa            (wdataa),
        .wea               (wea),
        .waddrb            (waddrb),
        .wdatab            (wdatab),
        .web               (web)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic herm;
        int   log2n;
        int   nbeats;
        int   tlast_at;
        int   gap_at;
        int   gap_len;
        int   pat;        // 0: re=k, im=k+100; 1: random; 2: random with im=-32768 at k=1
        logic exp_early;
        logic exp_missing;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t qa[$];
    wr_t qb[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] bitrev_m(input logic [AW-1:0] a, input int l);
        logic [AW-1:0] r = '0;
        for (int i = 0; i < l; i++) r[i] = a[l-1-i];
        return r;
    endfunction

    function automatic logic [AW-1:0] map_addr(input int a, input int l);
        logic [AW-1:0] v = AW'(a % (1 << l));
`ifdef AXIS_BRAM_BITREV_EN
        return bitrev_m(v, l);
`else
        return v;
`endif
    endfunction

    function automatic logic [SW-1:0] neg_m(input logic [SW-1:0] x);
        int v = -int'($signed(x));
        if (v > 32767) v = 32767;
        return v[SW-1:0];
    endfunction

    function automatic vec_t mk(input logic h, input int l, input int nb, input int tl,
                                input int ga, input int gl, input int p,
                                input logic ee, input logic em);
        vec_t v;
        v.herm = h; v.log2n = l; v.nbeats = nb; v.tlast_at = tl;
        v.gap_at = ga; v.gap_len = gl; v.pat = p;
        v.exp_early = ee; v.exp_missing = em;
        return v;
    endfunction

    always @(negedge clk) begin
        if (wea) begin
            if (qa.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL wea_unexpected: got addr %0h, want no write", waddra);
            end else begin
                wr_t e;
                e = qa.pop_front();
                check("waddra", 64'(waddra), 64'(e.addr));
                check("wdataa", 64'(wdataa), 64'(e.data));
            end
        end
        if (web) begin
            if (qb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL web_unexpected: got addr %0h, want no write", waddrb);
            end else begin
                wr_t e;
                e = qb.pop_front();
                check("waddrb", 64'(waddrb), 64'(e.addr));
                check("wdatab", 64'(wdatab), 64'(e.data));
            end
        end
        if (done) done_cnt++;
    end

    task automatic start_go(input int l, input logic h);
        @(posedge clk); #1;
        go = 1'b1; cfg_log2_n = 4'(l); cfg_hermitian = h;
        @(posedge clk); #1;
        go = 1'b0;
    endtask

    task automatic drive_beat(input int b, input vec_t v, input logic push);
        int n = 1 << v.log2n;
        logic [SW-1:0] re, im;
        if (v.pat == 0) begin
            re = SW'(b); im = SW'(b + 100);
        end else begin
            re = SW'($urandom_range(0, 65535));
            im = SW'($urandom_range(0, 65535));
            if (v.pat == 2 && b == 1) im = 16'h8000;
        end
        s_axis_tdata  = {16'($urandom_range(0, 65535)), im, 16'($urandom_range(0, 65535)), re};
        s_axis_tkeep  = 8'($urandom_range(0, 255));
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = (b == v.tlast_at);
        if (push) begin
            qa.push_back('{map_addr(b, v.log2n), {re, im}});
            if (v.herm && b > 0 && b < n / 2)
                qb.push_back('{map_addr(n - b, v.log2n), {re, neg_m(im)}});
        end
    endtask

    task automatic run_frame(input int id, input vec_t v);
        start_go(v.log2n, v.herm);
        check("busy_after_go", 64'(busy), 64'(1));
        check("early_cleared", 64'(err_tlast_early), 64'(0));
        check("missing_cleared", 64'(err_tlast_missing), 64'(0));
        done_cnt = 0;
        for (int b = 0; b < v.nbeats; b++) begin
            if (b == v.gap_at) begin
                s_axis_tvalid = 1'b0;
                repeat (v.gap_len) begin
                    @(posedge clk); #1;
                end
            end
            drive_beat(b, v, 1'b1);
            @(negedge clk);
            if (s_axis_tready !== 1'b1) check("tready_in_write", 64'(s_axis_tready), 64'(1));
            if (v.pat == 2 && b == 1) check("sat_neg_im", 64'(wdatab[SW-1:0]), 64'h7fff);
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check("done_pulse", 64'(done), 64'(1));
        check("tready_in_done", 64'(s_axis_tready), 64'(0));
        check("err_early", 64'(err_tlast_early), 64'(v.exp_early));
        check("err_missing", 64'(err_tlast_missing), 64'(v.exp_missing));
        @(posedge clk); #1;
        check("idle_after_done", 64'(busy), 64'(0));
        check("done_count", 64'(done_cnt), 64'(1));
        check("qa_drained", 64'(qa.size()), 64'(0));
        check("qb_drained", 64'(qb.size()), 64'(0));
        if (qa.size() != 0 || qb.size() != 0) begin
            $display("  frame %0d left %0d/%0d expected writes", id, qa.size(), qb.size());
            qa.delete(); qb.delete();
        end
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   bad_sizes[4];
        vec_t rv;

        vecs[0] = mk(1'b1, 4,    9,    8, -1,  0, 0, 1'b0, 1'b0);
        vecs[1] = mk(1'b0, 3,    8,    7,  4,  3, 1, 1'b0, 1'b0);
        vecs[2] = mk(1'b1, 4,    6,    5, -1,  0, 1, 1'b1, 1'b0);
        vecs[3] = mk(1'b0, 3,    8,   -1, -1,  0, 1, 1'b0, 1'b1);
        vecs[4] = mk(1'b1, 4,    9,    8, -1,  0, 2, 1'b0, 1'b0);
        vecs[5] = mk(1'b0, 12, 4096, 4095, 100, 2, 1, 1'b0, 1'b0);
        vecs[6] = mk(1'b1, 12, 2049, 2048, -1,  0, 1, 1'b0, 1'b0);
        vecs[7] = mk(1'b1, 3,    5,    4,  2,  1, 1, 1'b0, 1'b0);
        vecs[8] = mk(1'b0, 5,   32,   -1, -1,  0, 1, 1'b0, 1'b1);
        bad_sizes = '{2, 13, 0, 15};

        // reset state
        #2 reset = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_tready", 64'(s_axis_tready), 64'(0));
        check("rst_errs", 64'({err_cfg, err_tlast_early, err_tlast_missing}), 64'(0));
        check("rst_wr", 64'({wea, web, waddra, waddrb}), 64'(0));
        check("rst_data", {wdataa, wdatab}, 64'(0));
        @(negedge clk); #2 reset = 1'b1;

        for (int i = 0; i < 9; i++) run_frame(i, vecs[i]);

        // sticky missing flag survives idle cycles until cleared
        repeat (3) @(posedge clk);
        #1 check("missing_sticky", 64'(err_tlast_missing), 64'(1));

        // invalid sizes are rejected with a one-cycle err_cfg
        foreach (bad_sizes[i]) begin
            start_go(bad_sizes[i], 1'b0);
            check("err_cfg_pulse", 64'(err_cfg), 64'(1));
            check("busy_on_bad_cfg", 64'(busy), 64'(0));
            @(posedge clk); #1;
            check("err_cfg_clears", 64'(err_cfg), 64'(0));
            check("busy_stays_idle", 64'(busy), 64'(0));
        end

        // go while busy is ignored: a second go mid-frame must not restart the counter
        rv = mk(1'b0, 3, 8, 7, -1, 0, 1, 1'b0, 1'b0);
        start_go(3, 1'b0);
        drive_beat(0, rv, 1'b1);
        go = 1'b1; cfg_log2_n = 4'd4; cfg_hermitian = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        for (int b = 1; b < 8; b++) begin
            drive_beat(b, rv, 1'b1);
            @(posedge clk); #1;
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        check("busy_go_done", 64'(done), 64'(1));
        @(posedge clk); #1;
        check("busy_go_drained", 64'(qa.size() + qb.size()), 64'(0));
        qa.delete(); qb.delete();

        // asynchronous reset mid-frame, with a beat presented
        start_go(3, 1'b0);
        for (int b = 0; b < 3; b++) begin
            drive_beat(b, rv, 1'b1);
            @(posedge clk); #1;
        end
        drive_beat(3, rv, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_tready", 64'(s_axis_tready), 64'(0));
        check("async_rst_wea", 64'({wea, web}), 64'(0));
        check("async_rst_addr", 64'({waddra, waddrb}), 64'(0));
        check("async_rst_data", {wdataa, wdatab}, 64'(0));
        check("async_rst_flags", 64'({done, err_cfg, err_tlast_early, err_tlast_missing}), 64'(0));
        s_axis_tvalid = 1'b0;
        @(negedge clk); #2 reset = 1'b1;
        @(posedge clk); #1;
        check("idle_after_rst", 64'(busy), 64'(0));
        run_frame(100, vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
